// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified memory port arbiter.
// Contents: FSM state encoding, grant identifiers, default bus widths.
package riscv_mem_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side and memory-side handshake signals of the
// arbiter.
// Modports:
//   slave  - arbiter view: takes fetch/data requests and memory responses,
//            drives completions, read data, memory request and stall.
//   master - environment view (datapath plus memory model), the mirror image.
interface mem_port_arbiter_if
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_done;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_done;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;
  logic                  stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata, stall
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// Ports:
//   eligible[1:0] - bit GNT_IF / GNT_D set when that requester may be granted
//   last_grant    - requester granted most recently
//   grant_valid   - at least one requester is eligible
//   grant_id      - chosen requester (don't care when grant_valid is low)
module rr_pick2
  import riscv_mem_pkg::*;
(
  input  logic [1:0] eligible,
  input  grant_e     last_grant,
  output logic       grant_valid,
  output grant_e     grant_id
);

  always_comb begin
    grant_valid = |eligible;
    grant_id    = GNT_IF;
    unique case (eligible)
      2'b01:   grant_id = GNT_IF;
      2'b10:   grant_id = GNT_D;
      // Tie: favour whoever did not win last time.
      2'b11:   grant_id = (last_grant == GNT_IF) ? GNT_D : GNT_IF;
      default: grant_id = GNT_IF;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Grants one transaction at a time, drives the memory handshake from
// registers, returns read data to the winner and pulses its done for one
// cycle. stall is high while any request is still awaiting its done.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high
//   bus   - requester and memory signals (slave modport of mem_port_arbiter_if)
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  arb_state_e            state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  if_done_q, if_done_d;
  logic                  d_done_q, d_done_d;

  logic [1:0] eligible;
  logic       grant_valid;
  grant_e     grant_id;

  // A requester in its done cycle still holds req; masking it avoids a
  // second grant for the transaction that just finished.
  assign eligible[GNT_IF] = bus.if_req & ~if_done_q;
  assign eligible[GNT_D]  = bus.d_req & ~d_done_q;

  rr_pick2 u_pick (
    .eligible    (eligible),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_done_d    = 1'b0;
    d_done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          mem_req_d    = 1'b1;
          last_grant_d = grant_id;
          if (grant_id == GNT_D) begin
            state_d     = BUSY_D;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            state_d     = BUSY_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      BUSY_IF: begin
        if (bus.mem_ready) begin
          mem_req_d  = 1'b0;
          if_rdata_d = bus.mem_rdata;
          if_done_d  = 1'b1;
          state_d    = IDLE;
        end
      end
      BUSY_D: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
          d_done_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_IF;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_done_q    <= if_done_d;
      d_done_q     <= d_done_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.stall     = (bus.if_req & ~if_done_q) | (bus.d_req & ~d_done_q);

endmodule
